// File: rtl/pwm_capture.sv
// pwm_capture: APB3-mapped high-time / period capture of an asynchronous PWM input.
// Define PWM_CAPTURE_TIMEOUT_EN to build the edge-idle timeout that drives STATUS.TMO.

module pwm_capture #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    input  logic        pwm_in,
    output logic        capture_irq
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        HIGH_PH   = 2'd2,
        LOW_PH    = 2'd3
    } state_e;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_HIGH   = 2'd2;
    localparam logic [1:0] ADDR_PERIOD = 2'd3;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    state_e      state_q, state_d;
    logic [2:0]  sync_q, sync_d;
    logic        en_q, en_d, irq_en_q, irq_en_d;
    logic        valid_q, valid_d, ovr_q, ovr_d;
    logic [31:0] high_q, high_d, period_q, period_d;
    logic [31:0] high_cnt_q, high_cnt_d, period_cnt_q, period_cnt_d;
    logic        irq_q, irq_d;

    logic        rise, fall;
    logic        wr, wr_ctrl, wr_status;
    logic        capture, start_meas, high_run;
    logic        tmo_hit, tmo_bit;

    assign PREADY      = 1'b1;
    assign PSLVERR     = 1'b0;
    assign capture_irq = irq_q;

    // sync_q[1] is the synchronised input, sync_q[2] its one-cycle-old copy.
    assign sync_d = {sync_q[1:0], pwm_in};
    assign rise   = sync_q[1] & ~sync_q[2];
    assign fall   = ~sync_q[1] & sync_q[2];

    assign wr        = PSEL & PENABLE & PWRITE;
    assign wr_ctrl   = wr && (PADDR[3:2] == ADDR_CTRL);
    assign wr_status = wr && (PADDR[3:2] == ADDR_STATUS);

    logic unused_bits;
    assign unused_bits = ^{PADDR[31:4], PADDR[1:0], PWDATA[31:3]};

`ifdef PWM_CAPTURE_TIMEOUT_EN
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic [31:0] idle_cnt_q, idle_cnt_d;
    logic        tmo_q, tmo_d;

    always_comb begin
        idle_cnt_d = idle_cnt_q;
        tmo_hit    = 1'b0;
        if (!en_q || state_q == IDLE || rise || fall) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q >= TIMEOUT_LAST) begin
            tmo_hit    = 1'b1;
            idle_cnt_d = '0;
        end else begin
            idle_cnt_d = idle_cnt_q + 32'd1;
        end

        tmo_d = tmo_q;
        if (wr_status && PWDATA[2]) tmo_d = 1'b0;
        if (tmo_hit)                tmo_d = 1'b1;
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            idle_cnt_q <= '0;
            tmo_q      <= 1'b0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
            tmo_q      <= tmo_d;
        end
    end

    assign tmo_bit = tmo_q;
`else
    assign tmo_hit = 1'b0;
    assign tmo_bit = 1'b0;

    logic unused_timeout;
    assign unused_timeout = ^{PWDATA[2], 32'(TIMEOUT_CYCLES)};
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (en_q) state_d = WAIT_RISE;
            WAIT_RISE: if (rise) state_d = HIGH_PH;
            HIGH_PH:   if (fall) state_d = LOW_PH;
            LOW_PH:    if (rise) state_d = HIGH_PH;
            default:   state_d = IDLE;
        endcase
        if (tmo_hit) state_d = WAIT_RISE;
        if (!en_q)   state_d = IDLE;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        capture    = 1'b0;
        start_meas = 1'b0;
        high_run   = 1'b0;
        if (en_q) begin
            capture    = rise && (state_q == LOW_PH);
            start_meas = rise && (state_q == WAIT_RISE || state_q == LOW_PH);
            high_run   = (state_q == HIGH_PH) && !fall;
        end
    end

    // Counters restart at 1 on the rising edge so a steady N-cycle period reads exactly N.
    always_comb begin
        high_cnt_d   = high_cnt_q;
        period_cnt_d = period_cnt_q;
        if (!en_q || state_q == IDLE || tmo_hit) begin
            high_cnt_d   = '0;
            period_cnt_d = '0;
        end else if (start_meas) begin
            high_cnt_d   = 32'd1;
            period_cnt_d = 32'd1;
        end else begin
            if (state_q == HIGH_PH || state_q == LOW_PH) period_cnt_d = sat_inc(period_cnt_q);
            if (high_run)                                  high_cnt_d   = sat_inc(high_cnt_q);
        end
    end

    always_comb begin
        en_d     = en_q;
        irq_en_d = irq_en_q;
        valid_d  = valid_q;
        ovr_d    = ovr_q;
        high_d   = high_q;
        period_d = period_q;
        if (wr_ctrl) begin
            en_d     = PWDATA[0];
            irq_en_d = PWDATA[1];
        end
        if (wr_status && PWDATA[0]) valid_d = 1'b0;
        if (wr_status && PWDATA[1]) ovr_d   = 1'b0;
        // Sets are applied after clears so a coincident update wins.
        if (capture) begin
            valid_d  = 1'b1;
            if (valid_q) ovr_d = 1'b1;
            high_d   = high_cnt_q;
            period_d = period_cnt_q;
        end
        irq_d = irq_en_q & (valid_q | tmo_bit);
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            sync_q       <= '0;
            en_q         <= 1'b0;
            irq_en_q     <= 1'b0;
            valid_q      <= 1'b0;
            ovr_q        <= 1'b0;
            high_q       <= '0;
            period_q     <= '0;
            high_cnt_q   <= '0;
            period_cnt_q <= '0;
            irq_q        <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            en_q         <= en_d;
            irq_en_q     <= irq_en_d;
            valid_q      <= valid_d;
            ovr_q        <= ovr_d;
            high_q       <= high_d;
            period_q     <= period_d;
            high_cnt_q   <= high_cnt_d;
            period_cnt_q <= period_cnt_d;
            irq_q        <= irq_d;
        end
    end

    always_comb begin
        PRDATA = '0;
        if (PSEL) begin
            unique case (PADDR[3:2])
                ADDR_CTRL:   PRDATA = {30'd0, irq_en_q, en_q};
                ADDR_STATUS: PRDATA = {29'd0, tmo_bit, ovr_q, valid_q};
                ADDR_HIGH:   PRDATA = high_q;
                ADDR_PERIOD: PRDATA = period_q;
                default:     PRDATA = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed, table-driven check of pwm_capture over APB with a PWM generator.
// Expectations for the timeout follow whether PWM_CAPTURE_TIMEOUT_EN is defined.

module tb_pwm_capture;

    localparam logic [31:0] A_CTRL   = 32'h0;
    localparam logic [31:0] A_STATUS = 32'h4;
    localparam logic [31:0] A_HIGH   = 32'h8;
    localparam logic [31:0] A_PERIOD = 32'hC;

`ifdef PWM_CAPTURE_TIMEOUT_EN
    localparam logic EXP_TMO = 1'b1;
`else
    localparam logic EXP_TMO = 1'b0;
`endif

    logic        PCLK, PRESET, PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PREADY, PSLVERR, pwm_in, capture_irq;

    int checks   = 0;
    int failures = 0;

    int g_on     = 0;
    int g_period = 20;
    int g_high   = 7;
    int g_phase  = 0;

    typedef struct {
        int          period;
        int          high;
        logic [31:0] exp_high;
        logic [31:0] exp_period;
    } vec_t;

    vec_t vecs[$];

    pwm_capture #(.TIMEOUT_CYCLES(100)) dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR),
        .pwm_in      (pwm_in),
        .capture_irq (capture_irq)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // PWM source: high for phases [0, g_high), low for the rest of g_period.
    always @(negedge PCLK) begin
        if (g_on != 0) begin
            pwm_in  = (g_phase < g_high);
            g_phase = (g_phase + 1 >= g_period) ? 0 : g_phase + 1;
        end else begin
            pwm_in = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        @(negedge PCLK);
        PENABLE = 1'b1;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        #1 d = PRDATA;
        PSEL = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        apb_read(a, d);
        check(name, d, exp);
    endtask

    task automatic set_gen(input int period, input int high, input int start_phase);
        @(posedge PCLK);
        g_period = period;
        g_high   = high;
        g_phase  = start_phase;
        g_on     = 1;
    endtask

    // Returns at the first clock edge after the generator drives a rising edge.
    task automatic wait_rise(input string name, input int bound);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(posedge PCLK);
            if (g_on != 0 && g_phase == 1) ok = 1'b1;
        end
        check(name, {31'd0, ok}, 32'd1);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    initial begin
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; pwm_in = 1'b0;

        // Reset state, sampled while PRESET is still asserted.
        cycles(3);
        read_check("rst_ctrl",   A_CTRL,   32'd0);
        read_check("rst_status", A_STATUS, 32'd0);
        read_check("rst_high",   A_HIGH,   32'd0);
        read_check("rst_period", A_PERIOD, 32'd0);
        check("rst_irq",     {31'd0, capture_irq}, 32'd0);
        check("rst_pready",  {31'd0, PREADY},      32'd1);
        check("rst_pslverr", {31'd0, PSLVERR},     32'd0);
        @(negedge PCLK);
        PRESET = 1'b0;
        cycles(2);

        // Steady waveforms: {period, high, expected HIGH, expected PERIOD}.
`ifndef PWM_CAPTURE_TIMEOUT_EN
        vecs.push_back('{1000, 250, 32'd250, 32'd1000});
`endif
        vecs.push_back('{20, 7, 32'd7,  32'd20});
        vecs.push_back('{10, 1, 32'd1,  32'd10});
        vecs.push_back('{10, 9, 32'd9,  32'd10});
        vecs.push_back('{2,  1, 32'd1,  32'd2});
        vecs.push_back('{3,  2, 32'd2,  32'd3});

        foreach (vecs[i]) begin
            apb_write(A_CTRL, 32'd0);
            apb_write(A_STATUS, 32'd7);
            set_gen(vecs[i].period, vecs[i].high, vecs[i].high);
            apb_write(A_CTRL, 32'd1);
            cycles(4 * vecs[i].period + 20);
            read_check($sformatf("vec%0d_high", i),   A_HIGH,   vecs[i].exp_high);
            read_check($sformatf("vec%0d_period", i), A_PERIOD, vecs[i].exp_period);
            read_check($sformatf("vec%0d_status", i), A_STATUS, 32'd3);
        end

        // W1C of VALID|OVR with capture stopped; RO write ignored.
        apb_write(A_CTRL, 32'd0);
        apb_write(A_HIGH, 32'hDEAD_BEEF);
        apb_write(A_STATUS, 32'd3);
        read_check("w1c_status", A_STATUS, 32'd0);
        read_check("ro_high",    A_HIGH,   32'd2);
        read_check("ro_period",  A_PERIOD, 32'd3);

        // Interrupt, then a VALID clear landing on the same edge as an update.
        set_gen(20, 7, 7);
        apb_write(A_CTRL, 32'd3);
        cycles(100);
        check("irq_set", {31'd0, capture_irq}, 32'd1);
        read_check("ctrl_rb", A_CTRL, 32'd3);
        wait_rise("align_rise", 40);
        apb_write(A_STATUS, 32'd1);
        read_check("set_beats_clear", A_STATUS, 32'd3);
        apb_write(A_CTRL, 32'd2);
        apb_write(A_STATUS, 32'd7);
        cycles(3);
        check("irq_clr", {31'd0, capture_irq}, 32'd0);

        // Disable mid HIGH_PH, then re-enable and count rising edges.
        set_gen(40, 30, 30);
        apb_write(A_CTRL, 32'd1);
        cycles(180);
        read_check("dis_high0",   A_HIGH,   32'd30);
        read_check("dis_period0", A_PERIOD, 32'd40);
        wait_rise("dis_rise", 60);
        repeat (10) @(posedge PCLK);
        apb_write(A_CTRL, 32'd0);
        apb_write(A_STATUS, 32'd7);
        cycles(60);
        read_check("dis_high1",   A_HIGH,   32'd30);
        read_check("dis_period1", A_PERIOD, 32'd40);
        read_check("dis_status",  A_STATUS, 32'd0);
        set_gen(50, 20, 20);
        apb_write(A_CTRL, 32'd1);
        wait_rise("ren_rise1", 80);
        cycles(10);
        read_check("ren_status1", A_STATUS, 32'd0);
        read_check("ren_high1",   A_HIGH,   32'd30);
        wait_rise("ren_rise2", 80);
        cycles(6);
        read_check("ren_status2", A_STATUS, 32'd1);
        read_check("ren_high2",   A_HIGH,   32'd20);
        read_check("ren_period2", A_PERIOD, 32'd50);

        // Input held low: TMO only with the timeout built in.
        apb_write(A_CTRL, 32'd0);
        @(posedge PCLK);
        g_on = 0;
        apb_write(A_STATUS, 32'd7);
        apb_write(A_CTRL, 32'd3);
        cycles(50);
        read_check("tmo_early", A_STATUS, 32'd0);
        cycles(80);
        read_check("tmo_late", A_STATUS, {29'd0, EXP_TMO, 2'b00});
        check("tmo_irq", {31'd0, capture_irq}, {31'd0, EXP_TMO});
        apb_write(A_CTRL, 32'd0);
        apb_write(A_STATUS, 32'd4);
        read_check("tmo_clr", A_STATUS, 32'd0);

        // Asynchronous reset in the middle of a measurement.
        set_gen(20, 7, 7);
        apb_write(A_CTRL, 32'd3);
        cycles(100);
        check("pre_rst_irq", {31'd0, capture_irq}, 32'd1);
        read_check("pre_rst_high", A_HIGH, 32'd7);
        @(posedge PCLK);
        #2 PRESET = 1'b1;
        #1 check("arst_irq", {31'd0, capture_irq}, 32'd0);
        for (int r = 0; r < 4; r++) begin
            PSEL  = 1'b1;
            PADDR = 32'(r * 4);
            #1 check($sformatf("arst_reg%0d", r), PRDATA, 32'd0);
        end
        PSEL = 1'b0;
        @(negedge PCLK);
        PRESET = 1'b0;
        cycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000000, meaning PCLK cycles without a pwm_in edge before STATUS.TMO is set.
REQ-002 SHALL have port PCLK, input, 1 bit: the single clock.
REQ-003 SHALL have port PRESET, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have APB inputs PSEL, PENABLE, PWRITE (1 bit each), PADDR (32 bits) and PWDATA (32 bits), all with standard APB3 meaning.
REQ-005 SHALL have APB outputs PRDATA (32 bits), PREADY (1 bit, constant 1) and PSLVERR (1 bit, constant 0).
REQ-006 SHALL have port pwm_in, input, 1 bit: asynchronous PWM signal under measurement.
REQ-007 SHALL have port capture_irq, output, 1 bit: level interrupt.

Function
REQ-008 SHALL decode registers on PADDR[3:2]: 0 CTRL (RW; bit0 EN, bit1 IRQ_EN), 1 STATUS (bit0 VALID, bit1 OVR, bit2 TMO; write-1-to-clear), 2 HIGH (RO), 3 PERIOD (RO).
REQ-009 SHALL write only when PSEL, PENABLE and PWRITE are all high; writes to RO registers are ignored.
REQ-010 SHALL drive PRDATA combinationally from PADDR[3:2] while PSEL is high, and 0 otherwise; unused bits read 0.
REQ-011 SHALL synchronise pwm_in through two flops, then detect edges against a third delayed flop.
REQ-012 SHALL run an FSM with states IDLE, WAIT_RISE, HIGH_PH and LOW_PH.
REQ-013 FSM transitions SHALL be:
- IDLE -> WAIT_RISE when EN=1.
- WAIT_RISE -> HIGH_PH on a rising edge.
- HIGH_PH -> LOW_PH on a falling edge.
- LOW_PH -> HIGH_PH on a rising edge.
- Any state -> IDLE when EN=0.
REQ-014 SHALL update HIGH and PERIOD on each rising edge detected in LOW_PH, such that a stable input of period N cycles and high time H cycles yields PERIOD=N and HIGH=H exactly.
REQ-015 SHALL set VALID on every HIGH/PERIOD update; if VALID is already 1 at that update, SHALL also set OVR.
REQ-016 SHALL make an update visible on PRDATA no later than 3 PCLK cycles after the pwm_in rising edge that ends the period.
REQ-017 SHALL saturate the internal 32-bit counters at 0xFFFFFFFF, with no wrap-around.
REQ-018 SHALL give set priority over clear: a write-1-to-clear in the same cycle as a set leaves the bit at 1.
REQ-019 On EN 1->0 mid-measurement, SHALL discard the partial measurement and clear the counters, while HIGH, PERIOD and STATUS retain their values.
REQ-020 SHALL drive capture_irq = IRQ_EN AND (VALID OR TMO), registered.

Reset
REQ-021 On PRESET, SHALL asynchronously set CTRL, STATUS, HIGH, PERIOD, the counters, the synchroniser flops and capture_irq to 0, and the FSM to IDLE.
REQ-022 SHALL keep PREADY=1 and PSLVERR=0 during reset.

Configuration
REQ-023 With macro PWM_CAPTURE_TIMEOUT_EN defined:
- An edge-idle counter SHALL count while the FSM is not in IDLE.
- It SHALL restart on any detected edge.
- When it reaches TIMEOUT_CYCLES it SHALL set TMO and return the FSM to WAIT_RISE.
REQ-024 Without PWM_CAPTURE_TIMEOUT_EN, SHALL implement no timeout logic, and TMO SHALL read 0.

Verification
REQ-025 EN=1, pwm_in period 1000 cycles with 250 high -> after second rising edge HIGH=250, PERIOD=1000, VALID=1.
REQ-026 Two full periods with no STATUS clear -> OVR=1; write 0x3 to STATUS -> STATUS reads 0.
REQ-027 IRQ_EN=1 plus a valid sample -> capture_irq=1; write-1-clear of VALID in the same cycle as the next update -> VALID stays 1.
REQ-028 Clear EN mid HIGH_PH -> FSM to IDLE and HIGH/PERIOD unchanged; re-enable -> first update occurs only after two further rising edges.
REQ-029 With PWM_CAPTURE_TIMEOUT_EN and TIMEOUT_CYCLES=100, pwm_in held low for 100 cycles -> TMO=1; without the macro -> TMO=0.
REQ-030 Assert PRESET mid-measurement -> all registers read 0 and capture_irq=0 immediately, without waiting for a PCLK edge.
